rle_frame_ctrl: RTL and testbench

- Frame-level sequencer wrapped around the run-length encoder.
- Feeds pixels into the encoder and marks the last pixel of every line, so no run ever crosses a line boundary.
- Frames the encoder's token stream with start-of-frame (SOF) and end-of-frame (EOF) control tokens before it reaches the packer/UART path.
- Throttles upstream so that exactly one frame is in flight at a time.

---
 rtl/rle_frame_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rle_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_frame_ctrl.sv
// rle_frame_ctrl: frame sequencer around the run-length encoder.
// Feeds one frame of pixels to the encoder with end-of-line marks, and wraps the
// encoder's token stream in SOF/EOF control tokens. One frame in flight at a time.
//
// state  | meaning
// IDLE   | waiting for the first pixel of a frame (pixel left pending)
// SOF    | presenting the start-of-frame control token
// STREAM | pixels in, encoder tokens out, both pass-through
// DRAIN  | all pixels taken, forwarding the remaining encoder tokens
// EOF    | presenting the end-of-frame control token
module rle_frame_ctrl #(
  parameter int data_width_p  = 2,
  parameter int bus_width_p   = 8,
  parameter int count_width_p = bus_width_p - data_width_p,
  parameter int width_p       = 160,
  parameter int height_p      = 120
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [data_width_p-1:0] enc_data_o,
  output logic                    enc_last_o,
  output logic                    enc_valid_o,
  input  logic                    enc_ready_i,
  input  logic [bus_width_p-1:0]  enc_token_i,
  input  logic                    enc_token_last_i,
  input  logic                    enc_valid_i,
  output logic                    enc_ready_o,
  output logic [bus_width_p-1:0]  token_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    frame_done_o
);

  localparam int XW = (width_p  > 1) ? $clog2(width_p)  : 1;
  localparam int YW = (height_p > 1) ? $clog2(height_p) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(width_p - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(height_p - 1);

  // Control tokens carry a zero count field, which the encoder never produces.
  localparam logic [bus_width_p-1:0] SOF_TOK =
    {{count_width_p{1'b0}}, data_width_p'(1)};
  localparam logic [bus_width_p-1:0] EOF_TOK =
    {{count_width_p{1'b0}}, data_width_p'(2)};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_STREAM,
    ST_DRAIN,
    ST_EOF
  } state_t;

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [YW-1:0] r_lines_out;

  logic w_x_last;
  logic w_y_last;
  logic w_in_fire;
  logic w_in_done;
  logic w_out_fire;
  logic w_line_fire;
  logic w_out_done;

  assign w_x_last    = (r_x == X_MAX);
  assign w_y_last    = (r_y == Y_MAX);
  assign w_in_fire   = (r_state == ST_STREAM) && valid_i && enc_ready_i;
  assign w_in_done   = w_in_fire && w_x_last && w_y_last;
  assign w_out_fire  = ((r_state == ST_STREAM) || (r_state == ST_DRAIN)) &&
                       enc_valid_i && ready_i;
  assign w_line_fire = w_out_fire && enc_token_last_i;
  assign w_out_done  = w_line_fire && (r_lines_out == Y_MAX);

  // Frame sequencing plus pixel position and closed-line counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_lines_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i) r_state <= ST_SOF;
        end
        ST_SOF: begin
          if (ready_i) r_state <= ST_STREAM;
        end
        ST_STREAM, ST_DRAIN: begin
          if (w_in_fire) begin
            if (w_x_last) begin
              r_x <= '0;
              if (!w_y_last) r_y <= r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
          if (w_line_fire && !w_out_done) r_lines_out <= r_lines_out + 1'b1;
          // A final line token wins over the final pixel: nothing is left to drain.
          if (w_out_done)     r_state <= ST_EOF;
          else if (w_in_done) r_state <= ST_DRAIN;
        end
        ST_EOF: begin
          if (ready_i) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_lines_out <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output steering decoded from the registered state; data paths are pass-through.
  always_comb begin
    ready_o      = 1'b0;
    enc_data_o   = '0;
    enc_last_o   = 1'b0;
    enc_valid_o  = 1'b0;
    enc_ready_o  = 1'b0;
    token_o      = '0;
    valid_o      = 1'b0;
    busy_o       = (r_state != ST_IDLE);
    frame_done_o = 1'b0;
    case (r_state)
      ST_SOF: begin
        valid_o = 1'b1;
        token_o = SOF_TOK;
      end
      ST_STREAM: begin
        enc_data_o  = data_i;
        enc_valid_o = valid_i;
        enc_last_o  = w_x_last;
        ready_o     = enc_ready_i;
        token_o     = enc_token_i;
        valid_o     = enc_valid_i;
        enc_ready_o = ready_i;
      end
      ST_DRAIN: begin
        token_o     = enc_token_i;
        valid_o     = enc_valid_i;
        enc_ready_o = ready_i;
      end
      ST_EOF: begin
        valid_o      = 1'b1;
        token_o      = EOF_TOK;
        frame_done_o = ready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rle_frame_ctrl.sv
// Bench for rle_frame_ctrl on a 4x2 frame with a behavioural encoder model.
module tb_rle_frame_ctrl;
  localparam int DW = 2;
  localparam int BW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NP = W * H;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] enc_data_o;
  logic          enc_last_o;
  logic          enc_valid_o;
  logic          enc_ready_i;
  logic [BW-1:0] enc_token_i;
  logic          enc_token_last_i;
  logic          enc_valid_i;
  logic          enc_ready_o;
  logic [BW-1:0] token_o;
  logic          valid_o;
  logic          ready_i;
  logic          busy_o;
  logic          frame_done_o;

  always #5 clk_i = ~clk_i;

  rle_frame_ctrl #(.data_width_p(DW), .bus_width_p(BW), .width_p(W), .height_p(H)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .enc_data_o(enc_data_o), .enc_last_o(enc_last_o), .enc_valid_o(enc_valid_o),
    .enc_ready_i(enc_ready_i), .enc_token_i(enc_token_i), .enc_token_last_i(enc_token_last_i),
    .enc_valid_i(enc_valid_i), .enc_ready_o(enc_ready_o), .token_o(token_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .frame_done_o(frame_done_o));

  int total = 0;
  int bad   = 0;

  // Downstream / encoder readiness: 0 always ready, 1 toggling, 2 random.
  int rdy_mode = 0;
  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      1:       ready_i = ~ready_i;
      2:       ready_i = 1'($urandom_range(0, 1));
      default: ready_i = 1'b1;
    endcase
    enc_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Encoder model: one-cycle token latency, optionally zero-latency line close.
  logic [8:0] fq [16];
  int         wp, rp;
  logic [5:0] run_cnt;
  logic [1:0] run_val;
  bit         zl_mode = 1'b0;
  logic       zl_act;
  assign zl_act = zl_mode && (wp == rp) && enc_valid_o && enc_ready_i && enc_last_o &&
                  (run_cnt != 6'd0) && (run_val == enc_data_o);
  assign enc_valid_i      = (wp != rp) || zl_act;
  assign enc_token_i      = (wp != rp) ? fq[rp % 16][7:0] :
                            (zl_act ? {run_cnt + 6'd1, run_val} : 8'h00);
  assign enc_token_last_i = (wp != rp) ? fq[rp % 16][8] : zl_act;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wp <= 0; rp <= 0; run_cnt <= '0; run_val <= '0;
    end else begin
      int nwp;
      logic [5:0] c;
      logic [1:0] v;
      nwp = wp;
      if (enc_valid_i && enc_ready_o && (wp != rp)) rp <= rp + 1;
      if (enc_valid_o && enc_ready_i) begin
        c = run_cnt; v = run_val;
        if (c != 6'd0 && enc_data_o != v) begin
          fq[nwp % 16] <= {1'b0, c, v}; nwp++; c = 6'd0;
        end
        v = enc_data_o; c = c + 6'd1;
        if (enc_last_o) begin
          if (!(zl_act && enc_ready_o)) begin
            fq[nwp % 16] <= {1'b1, c, v}; nwp++;
          end
          c = 6'd0;
        end
        run_cnt <= c; run_val <= v;
      end
      wp <= nwp;
    end
  end

  // Monitor: collects fired tokens and watches protocol rules every cycle.
  logic [7:0] got[$];
  int cyc = 0, eof_cyc = 0, sof_cyc = 0;
  int fd_cnt = 0, fd_bad = 0, last_bad = 0, in_bad = 0, hold_bad = 0, in_cnt = 0;
  bit sof_seen = 0, prev_stall = 0;
  logic [7:0] prev_tok;
  always @(negedge clk_i) begin
    cyc++;
    if (reset_i) begin
      in_cnt = 0; sof_seen = 0; prev_stall = 0;
    end else begin
      if (prev_stall && !(valid_o && token_o == prev_tok)) hold_bad++;
      prev_stall = valid_o && !ready_i;
      prev_tok   = token_o;
      if (valid_i && ready_o) begin
        if (!sof_seen || in_cnt >= NP) in_bad++;
        if (enc_last_o !== ((in_cnt % W) == W - 1)) last_bad++;
        in_cnt++;
      end
      if (frame_done_o) begin
        fd_cnt++;
        if (!(valid_o && ready_i && token_o == 8'h02)) fd_bad++;
      end
      if (valid_o && ready_i) begin
        got.push_back(token_o);
        if (token_o == 8'h01) begin sof_seen = 1; sof_cyc = cyc; end
        if (token_o == 8'h02) begin eof_cyc = cyc; in_cnt = 0; sof_seen = 0; end
      end
    end
  end

  // Reference: expected framed token list straight from the run-length rules.
  logic [1:0] pix [NP];
  logic [7:0] exp_q[$];
  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(8'h01);
    for (int l = 0; l < H; l++) begin
      int n = 1;
      for (int x = 1; x <= W; x++) begin
        if (x == W || pix[l*W + x] != pix[l*W + x - 1]) begin
          exp_q.push_back({6'(n), pix[l*W + x - 1]});
          n = 1;
        end else n++;
      end
    end
    exp_q.push_back(8'h02);
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic rand_pix();
    for (int i = 0; i < NP; i++) pix[i] = 2'($urandom_range(0, 3));
  endtask

  // Present pixels 0..n-1 of pix; afterwards valid_i stays at keep with data nxt.
  task automatic send_pixels(input int n, input bit keep, input logic [1:0] nxt);
    int i = 0, guard = 0;
    bit f;
    valid_i = 1'b1; data_i = pix[0];
    while (i < n && guard < 400) begin
      @(negedge clk_i); f = valid_i && ready_o;
      @(posedge clk_i); #1; guard++;
      if (f) begin i++; if (i < n) data_i = pix[i]; end
    end
    chk("pixels_taken", i, n);
    valid_i = keep; data_i = nxt;
  endtask

  task automatic wait_eof(input string tag);
    int start = fd_cnt, guard = 0;
    while (fd_cnt == start && guard < 200) begin
      @(posedge clk_i); #1; guard++;
    end
    chk({tag, "_done_pulse"}, fd_cnt - start, 1);
  endtask

  task automatic cmp_tokens(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_tok"}, (i < got.size()) ? int'(got[i]) : -1, int'(exp_q[i]));
    got.delete();
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b1; enc_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 0);
    chk("rst_busy_o", busy_o, 0);
    chk("rst_enc_valid_o", enc_valid_o, 0);
    chk("rst_enc_ready_o", enc_ready_o, 0);
    chk("rst_token_o", token_o, 0);
    chk("rst_frame_done_o", frame_done_o, 0);
    @(posedge clk_i); #1; reset_i = 1'b0;
    got.delete();

    // Directed frame from the worked example.
    pix = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    build_exp();
    send_pixels(NP, 1'b0, 2'd0);
    wait_eof("frameA");
    chk("frameA_tok1", got.size() > 1 ? int'(got[1]) : -1, 8'h0D);
    chk("frameA_tok2", got.size() > 2 ? int'(got[2]) : -1, 8'h06);
    chk("frameA_tok3", got.size() > 3 ? int'(got[3]) : -1, 8'h12);
    cmp_tokens("frameA");
    repeat (3) @(posedge clk_i);
    #1 chk("idle_busy", busy_o, 0);

    // Same frame with downstream toggling.
    rdy_mode = 1;
    send_pixels(NP, 1'b0, 2'd0);
    wait_eof("frameB");
    cmp_tokens("frameB");
    rdy_mode = 0;
    repeat (2) @(posedge clk_i); #1;

    // Back-to-back frames with a pending ninth pixel held valid.
    rand_pix(); build_exp();
    begin
      logic [1:0] nxt[NP];
      for (int i = 0; i < NP; i++) nxt[i] = 2'($urandom_range(0, 3));
      send_pixels(NP, 1'b1, nxt[0]);
      wait_eof("frameC");
      cmp_tokens("frameC");
      pix = nxt;
    end
    build_exp();
    send_pixels(NP, 1'b0, 2'd0);
    chk("b2b_gap", sof_cyc - eof_cyc, 2);
    wait_eof("frameD");
    cmp_tokens("frameD");

    // Random frames with random downstream and encoder readiness.
    rdy_mode = 2;
    for (int k = 0; k < 3; k++) begin
      rand_pix(); build_exp();
      send_pixels(NP, 1'b0, 2'd0);
      wait_eof("frameR");
      cmp_tokens("frameR");
    end
    rdy_mode = 0;
    repeat (2) @(posedge clk_i); #1;

    // Asynchronous reset in the middle of the first line.
    rand_pix();
    send_pixels(2, 1'b1, pix[2]);
    #2 reset_i = 1'b1;
    #1;
    chk("async_busy_o", busy_o, 0);
    chk("async_ready_o", ready_o, 0);
    chk("async_valid_o", valid_o, 0);
    chk("async_enc_valid_o", enc_valid_o, 0);
    valid_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1 reset_i = 1'b0;
    got.delete();
    rand_pix(); build_exp();
    send_pixels(NP, 1'b0, 2'd0);
    wait_eof("frameG");
    cmp_tokens("frameG");
    repeat (2) @(posedge clk_i); #1;

    // Final pixel and final line token fire together.
    zl_mode = 1'b1;
    pix = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    build_exp();
    send_pixels(NP, 1'b0, 2'd0);
    @(negedge clk_i);
    chk("zl_eof_valid", valid_o, 1);
    chk("zl_eof_token", token_o, 8'h02);
    wait_eof("frameZ");
    cmp_tokens("frameZ");
    zl_mode = 1'b0;
    repeat (2) @(posedge clk_i); #1;

    chk("mon_hold", hold_bad, 0);
    chk("mon_enc_last", last_bad, 0);
    chk("mon_input_gate", in_bad, 0);
    chk("mon_done_pulse", fd_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
